// File: rtl/cmp_pkg.sv
// Shared definitions for the serial equality comparator.
//   - FSM state encoding (idle / run / done)
//   - clog2: ceiling log2, used to size the bit counter
package cmp_pkg;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   // Smallest r such that 2**r >= n (returns 0 for n <= 1).
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_eq_cmp_bit_eq.sv
// 1-bit equality cell.
//   a_i, b_i : bits to compare
//   eq_o     : 1 when a_i == b_i
module serial_eq_cmp_bit_eq (
   input  logic a_i,
   input  logic b_i,
   output logic eq_o
);

   assign eq_o = ~(a_i ^ b_i);

endmodule

// File: rtl/serial_eq_cmp.sv
// Serial equality comparator: compares two WIDTH-bit operands one bit per
// cycle, LSB first, optionally stopping at the first mismatching bit.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b sampled on accept)
//   out_valid/out_ready : result handshake
//   eq                  : 1 when all compared bits matched (0 outside DONE)
//   cycles              : number of bits compared (0 outside DONE)
module serial_eq_cmp
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              a,
   input  logic [WIDTH-1:0]              b,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          eq,
   output logic [clog2(WIDTH+1)-1:0]     cycles
);

   localparam int unsigned CntW = clog2(WIDTH + 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             acc_q, acc_d;

   logic             bit_eq;
   logic [CntW-1:0]  cnt_inc;
   logic             last_bit;

   serial_eq_cmp_bit_eq u_bit_eq (
      .a_i  (sa_q[0]),
      .b_i  (sb_q[0]),
      .eq_o (bit_eq)
   );

   assign cnt_inc  = cnt_q + CntW'(1);
   assign last_bit = (cnt_inc == CntW'(WIDTH));

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d = StRun;
               sa_d    = a;
               sb_d    = b;
               cnt_d   = '0;
               acc_d   = 1'b1;
            end
         end
         StRun: begin
            acc_d = acc_q & bit_eq;
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            cnt_d = cnt_inc;
            if (last_bit || (EARLY_EXIT && !bit_eq)) state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   // Results are forced to 0 outside DONE so stale accumulator state never leaks.
   assign eq        = out_valid & acc_q;
   assign cycles    = out_valid ? cnt_q : '0;

endmodule

// File: tb/tb_serial_eq_cmp.sv
// Bench for serial_eq_cmp: two instances (EARLY_EXIT=1 at index 1,
// EARLY_EXIT=0 at index 0) sharing clock, reset and operands.
module tb_serial_eq_cmp;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] in_valid, out_ready, in_ready, out_valid, eq;
   logic [7:0] a, b;
   logic [3:0] cycles [2];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_eq_cmp #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .a         (a),
      .b         (b),
      .out_valid (out_valid[1]),
      .out_ready (out_ready[1]),
      .eq        (eq[1]),
      .cycles    (cycles[1])
   );

   serial_eq_cmp #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_n (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .a         (a),
      .b         (b),
      .out_valid (out_valid[0]),
      .out_ready (out_ready[0]),
      .eq        (eq[0]),
      .cycles    (cycles[0])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected result from the operands: first differing bit (LSB first)
   // ends the compare when early exit is enabled.
   function automatic void predict(input logic [7:0] av, input logic [7:0] bv,
                                   input bit early, output int cyc, output bit eqv);
      logic [7:0] diff;
      diff = av ^ bv;
      eqv  = (diff == 8'h00);
      cyc  = 8;
      if (!eqv && early) begin
         for (int i = 7; i >= 0; i--) if (diff[i]) cyc = i + 1;
      end
   endfunction

   // Transaction-level model: idle -> busy for cyc edges -> done until taken.
   bit started = 1'b0;
   bit m_busy [2];
   bit m_done [2];
   int m_left [2];
   int m_cyc  [2];
   bit m_eq   [2];

   always @(posedge clk) begin : model
      int c;
      bit e;
      started <= 1'b1;
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            m_busy[d] <= 1'b0;
            m_done[d] <= 1'b0;
            m_left[d] <= 0;
         end else if (!m_busy[d] && !m_done[d]) begin
            if (in_valid[d]) begin
               predict(a, b, d == 1, c, e);
               m_busy[d] <= 1'b1;
               m_left[d] <= c;
               m_cyc[d]  <= c;
               m_eq[d]   <= e;
            end
         end else if (m_busy[d]) begin
            if (m_left[d] == 1) begin
               m_busy[d] <= 1'b0;
               m_done[d] <= 1'b1;
            end
            m_left[d] <= m_left[d] - 1;
         end else if (out_ready[d]) begin
            m_done[d] <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("in_ready[%0d]", d), 32'(in_ready[d]), 32'(!(m_busy[d] || m_done[d])));
            chk($sformatf("out_valid[%0d]", d), 32'(out_valid[d]), 32'(m_done[d]));
            chk($sformatf("eq[%0d]", d), 32'(eq[d]), m_done[d] ? 32'(m_eq[d]) : 32'd0);
            chk($sformatf("cycles[%0d]", d), 32'(cycles[d]), m_done[d] ? 32'(m_cyc[d]) : 32'd0);
         end
      end
   end

   // One transaction on DUT d; operands are scrambled right after accept.
   task automatic do_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                        input int hold, output int lat, output logic eq_o,
                        output logic [3:0] cyc_o);
      @(posedge clk); #2;
      a = av;
      b = bv;
      in_valid[d]  = 1'b1;
      out_ready[d] = (hold == 0);
      @(posedge clk); #2;
      in_valid[d] = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      lat = 0;
      while (!out_valid[d] && lat < 40) begin
         @(posedge clk); #2;
         lat++;
      end
      if (!out_valid[d]) begin
         chk("out_valid_timeout", 32'd0, 32'd1);
         out_ready[d] = 1'b0;
         return;
      end
      eq_o  = eq[d];
      cyc_o = cycles[d];
      for (int i = 0; i < hold; i++) begin
         in_valid[d] = ~in_valid[d];
         a = 8'($urandom);
         b = 8'($urandom);
         @(posedge clk); #2;
         chk("hold_out_valid", 32'(out_valid[d]), 32'd1);
      end
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      @(posedge clk); #2;
      out_ready[d] = 1'b0;
      chk("after_take_out_valid", 32'(out_valid[d]), 32'd0);
      chk("after_take_in_ready", 32'(in_ready[d]), 32'd1);
   endtask

   initial begin
      int         lat, pc;
      bit         pe;
      logic       r_eq;
      logic [3:0] r_cyc;

      reset     = 1'b1;
      in_valid  = 2'b00;
      out_ready = 2'b00;
      a         = 8'h00;
      b         = 8'h00;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;

      chk("rst_in_ready", 32'(in_ready), 32'h3);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_eq", 32'(eq), 32'h0);
      chk("rst_cycles", 32'(cycles[1]), 32'h0);

      // Pin the model with hand-computed cases.
      predict(8'hA5, 8'hA4, 1'b1, pc, pe);
      chk("model_a5a4_cyc", 32'(pc), 32'd1);
      chk("model_a5a4_eq", 32'(pe), 32'd0);
      predict(8'h10, 8'h00, 1'b1, pc, pe);
      chk("model_1000_cyc", 32'(pc), 32'd5);
      predict(8'h01, 8'h00, 1'b0, pc, pe);
      chk("model_noexit_cyc", 32'(pc), 32'd8);

      do_op(1, 8'hA5, 8'hA5, 0, lat, r_eq, r_cyc);
      chk("a5a5_lat", 32'(lat), 32'd8);
      chk("a5a5_eq", 32'(r_eq), 32'd1);
      chk("a5a5_cyc", 32'(r_cyc), 32'd8);

      do_op(1, 8'hA5, 8'hA4, 0, lat, r_eq, r_cyc);
      chk("a5a4_lat", 32'(lat), 32'd1);
      chk("a5a4_eq", 32'(r_eq), 32'd0);
      chk("a5a4_cyc", 32'(r_cyc), 32'd1);

      do_op(1, 8'h00, 8'h80, 0, lat, r_eq, r_cyc);
      chk("0080_lat", 32'(lat), 32'd8);
      chk("0080_eq", 32'(r_eq), 32'd0);
      chk("0080_cyc", 32'(r_cyc), 32'd8);

      do_op(1, 8'h10, 8'h00, 0, lat, r_eq, r_cyc);
      chk("1000_lat", 32'(lat), 32'd5);
      chk("1000_cyc", 32'(r_cyc), 32'd5);

      do_op(0, 8'h01, 8'h00, 0, lat, r_eq, r_cyc);
      chk("noexit_lat", 32'(lat), 32'd8);
      chk("noexit_eq", 32'(r_eq), 32'd0);
      chk("noexit_cyc", 32'(r_cyc), 32'd8);

      do_op(0, 8'h3C, 8'h3C, 0, lat, r_eq, r_cyc);
      chk("noexit_eq_eq", 32'(r_eq), 32'd1);

      do_op(1, 8'h5A, 8'h5A, 5, lat, r_eq, r_cyc);
      chk("hold_lat", 32'(lat), 32'd8);
      chk("hold_eq", 32'(r_eq), 32'd1);
      chk("hold_cyc", 32'(r_cyc), 32'd8);

      // Reset sampled on the 3rd RUN edge.
      @(posedge clk); #2;
      a = 8'hFF;
      b = 8'hFF;
      in_valid[1] = 1'b1;
      @(posedge clk); #2;
      in_valid[1] = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      chk("midrst_in_ready", 32'(in_ready[1]), 32'd1);
      chk("midrst_out_valid", 32'(out_valid[1]), 32'd0);

      do_op(1, 8'h3C, 8'h3C, 0, lat, r_eq, r_cyc);
      chk("post_rst_eq", 32'(r_eq), 32'd1);
      chk("post_rst_cyc", 32'(r_cyc), 32'd8);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
